// File: rtl/corr_window_reader_pkg.sv
// Shared types for the correlator window reader: FSM state encoding and
// the packed snapshot width helper.
package corr_window_reader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAlign = 2'd1,
        StRun   = 2'd2
    } state_e;

    // Snapshot word = four counts plus the window sequence number.
    function automatic int unsigned snap_width(input int unsigned time_w,
                                               input int unsigned seq_w);
        return 4 * time_w + seq_w;
    endfunction

endpackage

// File: rtl/corr_window_reader_snapshot_buf.sv
// Valid/ready snapshot buffer with sticky overrun flag.
// Depth is 1 by default, 2 (FIFO) when CORR_SNAPSHOT_SKID_EN is defined.
module corr_window_reader_snapshot_buf #(
    parameter int unsigned Width = 36
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o,
    output logic             overrun_o
);

    logic pop;
    logic drop;
    logic overrun_q;

`ifdef CORR_SNAPSHOT_SKID_EN
    logic [1:0]       cnt_q, cnt_d;
    logic [Width-1:0] e0_q, e0_d, e1_q, e1_d;
    logic             push_ok;

    // Pop first, then push into the first free slot; a full FIFO that is
    // popping in the same cycle still has room for the new entry.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        pop     = (cnt_q != 2'd0) && ready_i;
        if (pop) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end
        push_ok = push_i && (cnt_d != 2'd2);
        drop    = push_i && !push_ok;
        if (push_ok) begin
            if (cnt_d == 2'd0) begin
                e0_d = data_i;
            end else begin
                e1_d = data_i;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = e0_q;
`else
    logic             valid_q;
    logic [Width-1:0] data_q;
    logic             load;

    // A held snapshot is replaced only when it leaves in the same cycle.
    always_comb begin
        pop  = valid_q && ready_i;
        load = push_i && (!valid_q || ready_i);
        drop = push_i && !load;
    end

    // Single snapshot register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
`endif

    // Sticky overrun: a drop wins over a clearing transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (pop) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun_o = overrun_q;

endmodule

// File: rtl/corr_window_reader.sv
// Correlator window reader: times rectangular windows for the counter block,
// pulses its zero input at each window boundary and streams the four counts
// of every completed window as a snapshot. Optional 2-entry snapshot FIFO via
// CORR_SNAPSHOT_SKID_EN.
module corr_window_reader
    import corr_window_reader_pkg::*;
#(
    parameter int unsigned TIME_W = 8,
    parameter int unsigned SEQ_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cg,
    input  logic [TIME_W-1:0] i_winLen,
    output logic              o_zeroCounts,
    input  logic [TIME_W-1:0] i_countX,
    input  logic [TIME_W-1:0] i_countY,
    input  logic [TIME_W-1:0] i_countIsect,
    input  logic [TIME_W-1:0] i_countSymdiff,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [TIME_W-1:0] o_snapX,
    output logic [TIME_W-1:0] o_snapY,
    output logic [TIME_W-1:0] o_snapIsect,
    output logic [TIME_W-1:0] o_snapSymdiff,
    output logic [SEQ_W-1:0]  o_snapSeq,
    output logic              o_overrun
);

    localparam int unsigned SnapW = snap_width(TIME_W, SEQ_W);

    state_e            state_q;
    logic              zero_q;
    logic [TIME_W-1:0] len_q;
    logic [TIME_W-1:0] wc_q;
    logic [TIME_W-1:0] wc_inc;
    logic [SEQ_W-1:0]  seq_q;
    logic              capture;
    logic [SnapW-1:0]  cap_data;
    logic [SnapW-1:0]  snap_data;

    assign wc_inc   = wc_q + 1'b1;
    // The end cycle is the zero pulse seen while running; counts are complete.
    assign capture  = (state_q == StRun) && zero_q;
    assign cap_data = {i_countX, i_countY, i_countIsect, i_countSymdiff, seq_q};

    // Window FSM with registered zero pulse, window counter and sequence.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            zero_q  <= 1'b0;
            len_q   <= '0;
            wc_q    <= '0;
            seq_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    zero_q <= 1'b0;
                    if (i_winLen != '0) begin
                        state_q <= StAlign;
                        zero_q  <= 1'b1;
                    end
                end
                StAlign: begin
                    zero_q <= 1'b0;
                    len_q  <= i_winLen;
                    wc_q   <= '0;
                    // A length withdrawn during alignment never starts a window.
                    state_q <= (i_winLen != '0) ? StRun : StIdle;
                end
                StRun: begin
                    if (zero_q) begin
                        zero_q <= 1'b0;
                        seq_q  <= seq_q + 1'b1;
                        len_q  <= i_winLen;
                        wc_q   <= '0;
                        if (i_winLen == '0) begin
                            state_q <= StIdle;
                        end
                    end else if (i_cg) begin
                        wc_q <= wc_inc;
                        if (wc_inc == len_q) begin
                            zero_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    zero_q  <= 1'b0;
                end
            endcase
        end
    end

    corr_window_reader_snapshot_buf #(
        .Width (SnapW)
    ) u_snap_buf (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .push_i    (capture),
        .data_i    (cap_data),
        .valid_o   (o_valid),
        .ready_i   (i_ready),
        .data_o    (snap_data),
        .overrun_o (o_overrun)
    );

    assign o_zeroCounts = zero_q;
    assign {o_snapX, o_snapY, o_snapIsect, o_snapSymdiff, o_snapSeq} = snap_data;

endmodule

// File: tb/tb_corr_window_reader.sv
// Directed bench for corr_window_reader with a behavioural counter block.
module tb_corr_window_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cg, x, y, ready;
    logic [7:0] win_len;
    logic [7:0] cnt_x, cnt_y, cnt_i, cnt_s;
    logic       zero, valid, overrun;
    logic [7:0] snap_x, snap_y, snap_i, snap_s;
    logic [3:0] snap_seq;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int zero_cnt = 0;
    bit toggle_cg = 1'b0;

    always #5 clk = ~clk;

    corr_window_reader dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cg           (cg),
        .i_winLen       (win_len),
        .o_zeroCounts   (zero),
        .i_countX       (cnt_x),
        .i_countY       (cnt_y),
        .i_countIsect   (cnt_i),
        .i_countSymdiff (cnt_s),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_snapX        (snap_x),
        .o_snapY        (snap_y),
        .o_snapIsect    (snap_i),
        .o_snapSymdiff  (snap_s),
        .o_snapSeq      (snap_seq),
        .o_overrun      (overrun)
    );

    // Counter block: zero has priority over the sample enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_x <= 8'd0; cnt_y <= 8'd0; cnt_i <= 8'd0; cnt_s <= 8'd0;
        end else if (zero) begin
            cnt_x <= 8'd0; cnt_y <= 8'd0; cnt_i <= 8'd0; cnt_s <= 8'd0;
        end else if (cg) begin
            cnt_x <= cnt_x + {7'd0, x};
            cnt_y <= cnt_y + {7'd0, y};
            cnt_i <= cnt_i + {7'd0, x & y};
            cnt_s <= cnt_s + {7'd0, x ^ y};
        end
    end

    // Zero pulse counter used to prove silence while idle.
    always_ff @(posedge clk) begin
        if (zero) zero_cnt <= zero_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (toggle_cg) cg = ~cg;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset(input logic [7:0] len);
        rst_n = 1'b0;
        win_len = len;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            tick();
            n++;
        end
        if (!valid) chk({tag, "_timeout"}, {31'd0, valid}, 32'd1);
    endtask

    int z0;

    initial begin
        rst_n = 1'b0; cg = 1'b0; x = 1'b0; y = 1'b0; ready = 1'b0; win_len = 8'd5;

        // Reset holds everything at zero even with a non-zero length.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_snapx", {24'd0, snap_x}, 32'd0);
        chk("rst_seq", {28'd0, snap_seq}, 32'd0);
        rst_n = 1'b1;
        cyc = 0;
        goto(1);
        chk("rst_align_pulse", {31'd0, zero}, 32'd1);
        goto(2);
        chk("rst_run_nozero", {31'd0, zero}, 32'd0);

        // N=4, cg constant, x only, ready high.
        cg = 1'b1; x = 1'b1; y = 1'b0; ready = 1'b1;
        do_reset(8'd4);
        goto(1);  chk("n4_align", {31'd0, zero}, 32'd1);
        goto(5);  chk("n4_mid_nozero", {31'd0, zero}, 32'd0);
        goto(6);  chk("n4_end0", {31'd0, zero}, 32'd1);
        goto(7);
        chk("n4_valid0", {31'd0, valid}, 32'd1);
        chk("n4_x", {24'd0, snap_x}, 32'd4);
        chk("n4_y", {24'd0, snap_y}, 32'd0);
        chk("n4_isect", {24'd0, snap_i}, 32'd0);
        chk("n4_symdiff", {24'd0, snap_s}, 32'd4);
        chk("n4_seq0", {28'd0, snap_seq}, 32'd0);
        goto(8);  chk("n4_taken", {31'd0, valid}, 32'd0);
        goto(11); chk("n4_end1", {31'd0, zero}, 32'd1);
        goto(12); chk("n4_seq1", {28'd0, snap_seq}, 32'd1);
        goto(17); chk("n4_seq2", {28'd0, snap_seq}, 32'd2);

        // N=3, x=y=1, cg toggling.
        x = 1'b1; y = 1'b1; ready = 1'b1; cg = 1'b1; toggle_cg = 1'b1;
        do_reset(8'd3);
        wait_valid("n3", 40);
        chk("n3_x", {24'd0, snap_x}, 32'd3);
        chk("n3_y", {24'd0, snap_y}, 32'd3);
        chk("n3_isect", {24'd0, snap_i}, 32'd3);
        chk("n3_symdiff", {24'd0, snap_s}, 32'd0);
        chk("n3_seq", {28'd0, snap_seq}, 32'd0);
        toggle_cg = 1'b0;

        // Consumer stalls for three windows.
        cg = 1'b1; x = 1'b1; y = 1'b0; ready = 1'b0;
        do_reset(8'd4);
        goto(12);
`ifdef CORR_SNAPSHOT_SKID_EN
        chk("stall_w2_overrun", {31'd0, overrun}, 32'd0);
`else
        chk("stall_w2_overrun", {31'd0, overrun}, 32'd1);
`endif
        chk("stall_w2_seq", {28'd0, snap_seq}, 32'd0);
        goto(17);
        chk("stall_w3_valid", {31'd0, valid}, 32'd1);
        chk("stall_w3_seq", {28'd0, snap_seq}, 32'd0);
        chk("stall_w3_overrun", {31'd0, overrun}, 32'd1);
        goto(18);
        ready = 1'b1;
        goto(19);
        chk("release_overrun", {31'd0, overrun}, 32'd0);
`ifdef CORR_SNAPSHOT_SKID_EN
        chk("release_valid", {31'd0, valid}, 32'd1);
        chk("release_seq1", {28'd0, snap_seq}, 32'd1);
`else
        chk("release_valid", {31'd0, valid}, 32'd0);
`endif
        goto(22);
        chk("release_next_valid", {31'd0, valid}, 32'd1);
        chk("release_next_seq", {28'd0, snap_seq}, 32'd3);

        // Length dropped to 0 mid-window, then restarted with 2.
        cg = 1'b1; x = 1'b1; y = 1'b0; ready = 1'b1;
        do_reset(8'd4);
        goto(3);
        win_len = 8'd0;
        goto(7);
        chk("stop_x", {24'd0, snap_x}, 32'd4);
        chk("stop_seq", {28'd0, snap_seq}, 32'd0);
        z0 = zero_cnt;
        goto(20);
        chk("stop_silent", zero_cnt - z0, 32'd0);
        win_len = 8'd2;
        goto(21); chk("restart_align", {31'd0, zero}, 32'd1);
        goto(24); chk("restart_end", {31'd0, zero}, 32'd1);
        goto(25);
        chk("restart_x", {24'd0, snap_x}, 32'd2);
        chk("restart_seq", {28'd0, snap_seq}, 32'd1);

        // Sequence wrap with one-sample windows.
        cg = 1'b1; x = 1'b1; y = 1'b0; ready = 1'b1;
        do_reset(8'd1);
        for (int i = 0; i < 17; i++) begin
            wait_valid("wrap", 10);
            chk($sformatf("wrap_seq%0d", i), {28'd0, snap_seq}, i % 16);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
